gate_response_checker: RTL and testbench

//  Self-timed sweep engine and checker for small combinational gate DUTs (NAND/NOR/XOR/AND).

---
 rtl/gate_response_checker.sv | 175 +++++++++++++++++
 tb/tb_gate_response_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// Self-timed sweep engine and checker for a small 3-input combinational gate.
// Each sweep steps {a,b,c} through 000..111. Every vector settles for SETTLE
// cycles. The gate output d is then sampled once and compared against the
// expected function chosen by FUNC.
//
// Parameters
//   FUNC    expected function: 0=NAND, 1=NOR, 2=XOR, 3=AND (3-input)
//   SETTLE  settle cycles per vector before d is sampled (1..15)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   start       in   begin a sweep (honoured only in IDLE)
//   a, b, c     out  vector driven to the gate (a = MSB, c = LSB), from flops
//   d           in   gate output under test
//   busy        out  high in SETTLE and SAMPLE
//   done        out  one-cycle pulse while the FSM sits in DONE
//   pass        out  last sweep had zero mismatches (held until next start)
//   err_count   out  mismatches in the last sweep, 0..8
//   first_fail  out  vector of the first mismatch
//   fail_valid  out  first_fail is meaningful
//   dbg_state   out  FSM state: 0=IDLE, 1=SETTLE, 2=SAMPLE, 3=DONE
//
// Handshake: start is a level that is sampled on every rising edge. It has an
// effect only when the FSM is in IDLE. There is no ready signal. busy and
// done report progress, and results stay stable from done until the next
// accepted start.
// -----------------------------------------------------------------------------
module gate_response_checker #(
  parameter int FUNC   = 0,
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       fail_valid,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last settle count before moving to SAMPLE.
  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_vec, w_vec_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic [2:0] r_first, w_first_nxt;
  logic       r_fv, w_fv_nxt;
  logic       r_pass, w_pass_nxt;
  logic       r_done, w_done_nxt;
  logic       w_exp;
  logic       w_mismatch;

  // Expected gate output for the vector currently applied.
  always_comb begin
    w_exp = 1'b0;
    case (FUNC)
      0:       w_exp = ~(&r_vec);
      1:       w_exp = ~(|r_vec);
      2:       w_exp = ^r_vec;
      default: w_exp = &r_vec;
    endcase
  end

  // Case-inequality makes X/Z on d count as a mismatch in simulation.
  assign w_mismatch = (d !== w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    w_fv_nxt    = r_fv;
    w_pass_nxt  = r_pass;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_vec_nxt   = 3'd0;
          w_cnt_nxt   = 4'd0;
          w_err_nxt   = 4'd0;
          w_first_nxt = 3'd0;
          w_fv_nxt    = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LP_CNT_LAST) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_mismatch) begin
          w_err_nxt = r_err + 4'd1;
          if (!r_fv) begin
            w_first_nxt = r_vec;
            w_fv_nxt    = 1'b1;
          end
        end
        if (r_vec == 3'd7) begin
          // done and pass are registered on this edge, so both are valid
          // during the DONE cycle. pass uses the count that includes vector 7.
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 4'd0);
        end else begin
          w_vec_nxt   = r_vec + 3'd1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec   <= 3'd0;
      r_cnt   <= 4'd0;
      r_err   <= 4'd0;
      r_first <= 3'd0;
      r_fv    <= 1'b0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
      r_fv    <= w_fv_nxt;
      r_pass  <= w_pass_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign a          = r_vec[2];
  assign b          = r_vec[1];
  assign c          = r_vec[0];
  assign busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;
  assign fail_valid = r_fv;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

  localparam int P_SETTLE = 4;
  localparam int P_SWEEP  = 8 * (P_SETTLE + 1) + 1;  // 41

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial assert (P_SETTLE >= 1 && P_SETTLE <= 15)
    else $fatal(1, "SETTLE out of range 1..15: %0d", P_SETTLE);

  // ---------------- DUT 0: NAND checker ----------------
  logic       start0 = 1'b0;
  logic       a0, b0, c0, d0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic [1:0] st0;
  int         mode0 = 0;  // 0 ideal NAND, 1 tied 0, 2 tied 1

  always_comb begin
    d0 = 1'b0;
    case (mode0)
      0:       d0 = ~(a0 & b0 & c0);
      1:       d0 = 1'b0;
      default: d0 = 1'b1;
    endcase
  end

  gate_response_checker #(.FUNC(0), .SETTLE(P_SETTLE)) u_nand (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail(ff0), .fail_valid(fv0), .dbg_state(st0)
  );

  // ---------------- DUT 2: XOR checker ----------------
  logic       start2 = 1'b0;
  logic       a2, b2, c2, d2, busy2, done2, pass2, fv2;
  logic [3:0] err2;
  logic [2:0] ff2;
  logic [1:0] st2;
  int         mode2 = 0;  // 0 ideal XOR, 1 XNOR

  assign d2 = (mode2 == 0) ? (a2 ^ b2 ^ c2) : ~(a2 ^ b2 ^ c2);

  gate_response_checker #(.FUNC(2), .SETTLE(P_SETTLE)) u_xor (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail(ff2), .fail_valid(fv2), .dbg_state(st2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  // Pulses start on the selected instance. Returns the number of rising edges
  // from the start edge (inclusive) until done is seen, or -1 on timeout.
  task automatic sweep(input int inst, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      if ((inst == 0 && done0) || (inst != 0 && done2)) begin
        cyc  = n;
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, ff0, fv0, st0} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_nand: got %h required 0",
               {a0, b0, c0, busy0, done0, pass0, err0, ff0, fv0, st0});
    end
    n_checks++;
    if ({a2, b2, c2, busy2, done2, pass2, err2, ff2, fv2, st2} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_xor: got %h required 0",
               {a2, b2, c2, busy2, done2, pass2, err2, ff2, fv2, st2});
    end
  endtask

  task automatic test_nand_ideal;
    int bad_vec, bad_busy, bad_done;
    bad_vec = 0; bad_busy = 0; bad_done = 0;
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);          // start edge (edge 0)
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 8 * (P_SETTLE + 1); k++) begin
      // After edge k the vector is k/(SETTLE+1).
      if ({a0, b0, c0} !== 3'(k / (P_SETTLE + 1))) bad_vec++;
      if (busy0 !== 1'b1) bad_busy++;
      if (done0 !== 1'b0) bad_done++;
      @(negedge clk);
    end
    n_checks++;
    if (bad_vec != 0) begin
      n_fail++; $display("FAIL vec_steps: got %0d wrong cycles required 0", bad_vec);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++; $display("FAIL busy_sweep: got %0d low cycles required 0", bad_busy);
    end
    n_checks++;
    if (bad_done != 0) begin
      n_fail++; $display("FAIL done_early: got %0d early cycles required 0", bad_done);
    end
    // Now 41st cycle after the start edge: DONE state.
    n_checks++;
    if ({done0, busy0, pass0, err0, fv0} !== {1'b1, 1'b0, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL nand_ideal_done: got done=%b busy=%b pass=%b err=%0d fv=%b required 1 0 1 0 0",
               done0, busy0, pass0, err0, fv0);
    end
    @(negedge clk);
    n_checks++;
    if ({done0, pass0, st0} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL done_pulse_len: got done=%b pass=%b state=%0d required 0 1 0",
               done0, pass0, st0);
    end
  endtask

  task automatic test_nand_tied0;
    int cyc;
    mode0 = 1;
    sweep(0, cyc);
    n_checks++;
    if (cyc !== P_SWEEP) begin
      n_fail++; $display("FAIL tied0_latency: got %0d required %0d", cyc, P_SWEEP);
    end
    n_checks++;
    if ({err0, ff0, fv0, pass0} !== {4'd7, 3'b000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL tied0_result: got err=%0d ff=%b fv=%b pass=%b required 7 000 1 0",
               err0, ff0, fv0, pass0);
    end
  endtask

  task automatic test_nand_tied1;
    int cyc;
    mode0 = 2;
    sweep(0, cyc);
    n_checks++;
    if (cyc !== P_SWEEP) begin
      n_fail++; $display("FAIL tied1_latency: got %0d required %0d", cyc, P_SWEEP);
    end
    n_checks++;
    if ({err0, ff0, fv0, pass0} !== {4'd1, 3'b111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL tied1_result: got err=%0d ff=%b fv=%b pass=%b required 1 111 1 0",
               err0, ff0, fv0, pass0);
    end
  endtask

  task automatic test_xor;
    int cyc;
    mode2 = 0;
    sweep(2, cyc);
    n_checks++;
    if ({cyc == P_SWEEP, pass2, err2, fv2} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL xor_ideal: got cyc=%0d pass=%b err=%0d fv=%b required %0d 1 0 0",
               cyc, pass2, err2, fv2, P_SWEEP);
    end
    mode2 = 1;
    sweep(2, cyc);
    n_checks++;
    if ({cyc == P_SWEEP, pass2, err2, ff2, fv2} !== {1'b1, 1'b0, 4'd8, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL xor_xnor_dut: got cyc=%0d pass=%b err=%0d ff=%b fv=%b required %0d 0 8 000 1",
               cyc, pass2, err2, ff2, fv2, P_SWEEP);
    end
  endtask

  task automatic test_back_to_back;
    int  cyc, busy_seen;
    bit  seen;
    mode0 = 0;
    cyc = -1; seen = 1'b0; busy_seen = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      if (n == 10) start0 = 1'b1;       // sampled mid-sweep, must be ignored
      if (n == 11) start0 = 1'b0;
      if (done0) begin
        cyc = n; seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    n_checks++;
    if (cyc !== P_SWEEP) begin
      n_fail++; $display("FAIL restart_ignored_latency: got %0d required %0d", cyc, P_SWEEP);
    end
    // start during the done cycle is ignored as well.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (busy0 !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy_seen == 0, pass0, st0} !== {1'b1, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL start_on_done: got busy_cycles=%0d pass=%b state=%0d required 0 1 0",
               busy_seen, pass0, st0);
    end
  endtask

  task automatic test_reset_mid;
    int  cyc, done_seen;
    bit  found;
    mode0 = 1;
    found = 1'b0; done_seen = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if ({a0, b0, c0} == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if ({found, err0, fv0} !== {1'b1, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_sweep_state: got found=%b err=%0d fv=%b required 1 3 1", found, err0, fv0);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, ff0, fv0, st0} !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0",
               {a0, b0, c0, busy0, done0, pass0, err0, ff0, fv0, st0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done0 !== 1'b0 || busy0 !== 1'b0) done_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL no_done_after_reset: got %0d active cycles required 0", done_seen);
    end
    mode0 = 0;
    sweep(0, cyc);
    n_checks++;
    if ({cyc == P_SWEEP, pass0, err0, fv0} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sweep_after_reset: got cyc=%0d pass=%b err=%0d fv=%b required %0d 1 0 0",
               cyc, pass0, err0, fv0, P_SWEEP);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_nand_ideal;
    test_nand_tied0;
    test_nand_tied1;
    test_xor;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
